// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: converter FSM states and the
// product / BCD sizing used by the multiplier, converter and display driver.
package calc_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int PRODUCT_W   = 16;
  localparam int BCD_DIGITS  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } conv_state_e;

endpackage

// File: rtl/product_bcd_converter_bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Leading-zero blank mask is built only when PRODUCT_BCD_BLANK_EN is defined.
module product_bcd_converter
  import calc_pkg::*;
#(
  parameter int WIDTH  = PRODUCT_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]             blank
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = BCD_DIGIT_W * DIGITS;

  conv_state_e                          state_q, state_d;
  logic [CW-1:0]                        cnt_q, cnt_d;
  logic [WIDTH-1:0]                     sr_q, sr_d;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0]   scr_q, scr_d;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0]   corr;
  logic [SW-1:0]                        bcd_q, bcd_d;
  logic                                 busy_q, busy_d;
  logic                                 done_q, done_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (scr_q[g]),
      .digit_o (corr[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bin;
          scr_d   = '0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Digit sizing guarantees the bit shifted out of the top digit is always 0.
        {scr_d, sr_d} = {corr, sr_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FINISH;
      end
      FINISH: begin
        bcd_d   = scr_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

`ifdef PRODUCT_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_calc;
  logic              zero_above;

  // Units digit is never blanked so a zero result still shows "0".
  always_comb begin
    zero_above = 1'b1;
    blank_calc = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (scr_q[i] == 4'd0);
      blank_calc[i] = zero_above;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
    else if (state_q == FINISH) blank_q <= blank_calc;
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench for product_bcd_converter: decimal reference model checked every
// cycle, plus literal checks on results, latency, throughput and reset abort.
module tb_product_bcd_converter;

  localparam int W = 16;
  localparam int D = 5;

`ifdef PRODUCT_BCD_BLANK_EN
  localparam logic [D-1:0] BLANK_RST = 5'b11110;
  localparam bit           BLANK_ON  = 1'b1;
`else
  localparam logic [D-1:0] BLANK_RST = 5'b00000;
  localparam bit           BLANK_ON  = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n, start;
  logic [W-1:0]   bin;
  logic           busy, done;
  logic [4*D-1:0] bcd;
  logic [D-1:0]   blank;

  int total = 0;
  int pass  = 0;
  int cyc   = 0;

  product_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .blank(blank)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    r = '0;
    for (int d = 0; d < D; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Blank every digit position at or above the count of significant decimal digits.
  function automatic logic [D-1:0] exp_blank(input int v);
    logic [D-1:0] b;
    int n, t;
    b = '0;
    n = 1;
    t = v;
    while (t >= 10) begin t = t / 10; n++; end
    if (BLANK_ON)
      for (int i = 1; i < D; i++) b[i] = (i >= n);
    return b;
  endfunction

  // Reference model: accept when idle, result appears WIDTH+1 edges later.
  int           m_phase;
  int           m_val;
  logic         m_busy, m_done;
  logic [4*D-1:0] m_bcd;
  logic [D-1:0] m_blank;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_val <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_bcd <= '0; m_blank <= BLANK_RST;
    end else begin
      m_done <= 1'b0;
      if (m_phase == 0) begin
        if (start) begin m_val <= int'(bin); m_phase <= 1; m_busy <= 1'b1; end
      end else if (m_phase < W + 1) begin
        m_phase <= m_phase + 1;
      end else begin
        m_phase <= 0; m_busy <= 1'b0; m_done <= 1'b1;
        m_bcd <= to_bcd(m_val); m_blank <= exp_blank(m_val);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_busy", busy, m_busy);
      chk("model_done", done, m_done);
      chk("model_bcd", bcd, m_bcd);
      chk("model_blank", blank, m_blank);
      if (busy && done) chk("busy_done_overlap", 1, 0);
    end
  end

  task automatic run(input logic [W-1:0] v, output int lat, output int bcyc);
    @(negedge clk);
    start = 1'b1; bin = v;
    @(posedge clk); #1;
    start = 1'b0; bin = 16'($urandom);
    bcyc = busy ? 1 : 0;
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcyc++;
    end
    if (lat >= 60) chk("done_timeout", 0, 1);
  endtask

  int lat, bcyc, ndone, t_acc, t_prev;
  logic [W-1:0] prod;

  initial begin
    rst_n = 1'b0; start = 1'b0; bin = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_blank", blank, BLANK_RST);
    rst_n = 1'b1;

    run(16'd0, lat, bcyc);
    chk("zero_lat", lat, 17);
    chk("zero_bcd", bcd, 20'h00000);
    chk("zero_blank", blank, BLANK_ON ? 5'b11110 : 5'b00000);

    run(16'hFE01, lat, bcyc);
    chk("fe01_lat", lat, 17);
    chk("fe01_busy_cycles", bcyc, 17);
    chk("fe01_bcd", bcd, 20'h65025);

    run(16'hFFFF, lat, bcyc);
    chk("ffff_bcd", bcd, 20'h65535);
    chk("ffff_blank", blank, 5'b00000);

    run(16'd42, lat, bcyc);
    chk("d42_bcd", bcd, 20'h00042);
    chk("d42_blank", blank, BLANK_ON ? 5'b11100 : 5'b00000);

    // Starts during busy must be ignored.
    @(negedge clk); start = 1'b1; bin = 16'd999;
    @(posedge clk); #1; start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      start = (c == 3 || c == 10);
      if (start) bin = 16'd1234;
      @(posedge clk); #1;
      if (done) ndone++;
    end
    start = 1'b0;
    chk("ignore_done_count", ndone, 1);
    chk("ignore_bcd", bcd, 20'h00999);
    run(16'd1234, lat, bcyc);
    chk("after_ignore_bcd", bcd, 20'h01234);

    // Mid-conversion reset aborts without done.
    @(negedge clk); start = 1'b1; bin = 16'd500;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bcd", bcd, 0);
    chk("abort_blank", blank, BLANK_RST);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (25) begin @(posedge clk); #1; if (done) ndone++; end
    chk("abort_no_done", ndone, 0);
    run(16'd500, lat, bcyc);
    chk("after_abort_bcd", bcd, 20'h00500);

    // Back-to-back: start raised while done is visible.
    run(16'd7, lat, bcyc);
    t_prev = -1;
    for (int i = 0; i < 100; i++) begin
      prod  = 16'($urandom_range(0, 255) * $urandom_range(0, 255));
      start = 1'b1; bin = prod;
      @(posedge clk); #1;
      start = 1'b0;
      t_acc = cyc;
      if (t_prev >= 0) chk("b2b_period", t_acc - t_prev, 18);
      t_prev = t_acc;
      lat = 0;
      while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
      chk("b2b_lat", lat, 17);
      chk("b2b_bcd", bcd, to_bcd(int'(prod)));
    end

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/product_bcd_converter.md
# product_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the 8x8 array multiplier in the calculator datapath. It captures the 16-bit unsigned product on a start strobe and converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It presents five packed BCD digits, with a done pulse, to the seven-segment display driver.

## Interface
- `WIDTH`, default 16: binary input width; must equal the multiplier product width.
- `DIGITS`, default 5: BCD digit count; must satisfy 10^DIGITS > 2^WIDTH - 1.
- `clk` input, 1 bit: single system clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `start` input, 1 bit: request conversion of `bin`; sampled only in IDLE.
- `bin` input, WIDTH bits: unsigned binary value, the multiplier `out`; sampled on the accepted `start` cycle only.
- `busy` output, 1 bit: high while a conversion is in progress.
- `done` output, 1 bit: one-cycle pulse when `bcd` is updated.
- `bcd` output, 4*DIGITS bits: packed BCD result; digit 0 (units) in bits [3:0]; registered.
- `blank` output, DIGITS bits: per-digit leading-zero blank mask; bit i high means digit i should be blanked.

## Operation
- FSM states are IDLE, SHIFT and FINISH.
- IDLE: if `start` is high, load the shift register with `bin`, clear the BCD scratch, set the bit counter to WIDTH, set `busy`, and go to SHIFT. Otherwise stay in IDLE.
- SHIFT, per cycle:
  - Each scratch digit >= 5 gets +3 (4-bit, no carry out).
  - Then {scratch, shift register} shifts left by 1.
  - The counter decrements.
  - When the counter reaches 0 after the shift, go to FINISH.
- FINISH: copy scratch to `bcd`, compute `blank`, pulse `done`, clear `busy`, and return to IDLE.
- `start` while `busy` is ignored; no queuing, and the in-flight conversion is unaffected.
- `start` in the FINISH cycle is also ignored. A new `start` is accepted the cycle after `done`.
- `bcd` and `blank` hold their last values until the next FINISH.
- `bin` may change freely after the accept cycle.
- Arithmetic: scratch is 4*DIGITS bits. By the DIGITS rule above, no digit can exceed 9 and no overflow is possible.
- Reset, including mid-conversion: FSM goes to IDLE and the counter, shift register and scratch are cleared. The aborted conversion produces no `done`.

## Timing
- Reset values:
  - `busy` = 0, `done` = 0, `bcd` = 0.
  - `blank` = all ones except bit 0 when the blanking macro is defined; all zeros otherwise.
- Latency, with `start` accepted at edge N:
  - `busy` is high from N+1 through N+WIDTH+1.
  - `done` and the new `bcd` are visible in the cycle after edge N+WIDTH+1, i.e. WIDTH+1 cycles after accept (17 for defaults).
- Back-to-back throughput: one conversion per WIDTH+2 cycles.
- `done` is high for exactly one cycle and is never asserted together with `busy`.

## Configuration
- `PRODUCT_BCD_BLANK_EN` defined:
  - `blank[i]` = 1 iff digit i and all more-significant digits are zero, for i >= 1.
  - `blank[0]` is always 0, so a value of 0 shows a single "0".
  - `blank` updates in FINISH, together with `bcd`.
- Macro not defined: `blank` is tied to all zeros, and no blanking logic is synthesised.

## Structure
- Shared package `calc_pkg` holds:
  - the FSM state enum (IDLE, SHIFT, FINISH);
  - `BCD_DIGIT_W` = 4;
  - default `PRODUCT_W` = 16 and `BCD_DIGITS` = 5, also used by the multiplier and the display driver.
- One sub-module, `bcd_add3`: combinational 4-bit digit correction (in >= 5 ? in+3 : in), instantiated DIGITS times in a generate loop.
- Counter width is $clog2(WIDTH+1).

## Test plan
- Reset then `start` with `bin`=0 -> after 17 cycles `done`=1, `bcd`=20'h00000, `blank`=5'b11110 (macro on) or 5'b00000 (macro off).
- `bin`=16'hFE01 (255*255=65025) -> `bcd`=20'h65025 exactly 17 cycles after accept; `busy` high for 17 cycles.
- `bin`=16'hFFFF -> `bcd`=20'h65535, `blank`=5'b00000; `bin`=42 -> `bcd`=20'h00042, `blank`=5'b11100 (macro on).
- `start` pulsed with `bin`=1234 at cycles 3 and 10 of a conversion of 999 -> only one `done`, `bcd`=20'h00999. The next `start` after `done` converts correctly.
- Assert `rst_n` low at cycle 8 of a conversion of 500 -> `busy`, `done` and `bcd` return to reset values with no `done` pulse. A fresh `start` with 500 gives 20'h00500.
- Back-to-back: `start` asserted the cycle after each `done` for 100 random products A*B -> every `bcd` matches the reference decimal value, with period 18 cycles.
